// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO (rclk domain).
// Read pointer, write-pointer sync, empty flags and registered read data.
module fifo_rd_ctrl #(
  parameter int DATASIZE      = 8,
  parameter int ADDRSIZE      = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rden,
  input  logic [ADDRSIZE:0]   wptr_gray,
  input  logic [DATASIZE-1:0] rdata_mem,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr_gray,
  output logic [DATASIZE-1:0] odata,
  output logic                rd_valid,
  output logic                rd_empty,
  output logic                rd_almost_empty,
  output logic                rd_underflow
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0]       r_rbin;
  logic [PW-1:0]       r_rgray;
  logic [PW-1:0]       r_wq1;
  logic [PW-1:0]       r_wq2;
  logic [DATASIZE-1:0] r_odata;
  logic                r_valid;
  logic                r_empty;
  logic                r_aempty;
  logic                r_uflow;

  logic                w_accept;
  logic [PW-1:0]       w_rbin_next;
  logic [PW-1:0]       w_rgray_next;
  logic [PW-1:0]       w_wbin;
  logic [PW-1:0]       w_occ;

  // Bit i of the binary value is the XOR of Gray bits i and above.
  function automatic logic [PW-1:0] gray2bin(
    input logic [PW-1:0] g
  );
    logic [PW-1:0] b;
    for (int i = 0; i < PW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  assign w_accept     = rden & ~r_empty;
  assign w_rbin_next  = r_rbin + PW'(w_accept);
  assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;
  assign w_wbin       = gray2bin(r_wq2);
  assign w_occ        = w_wbin - w_rbin_next;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_wq1 <= '0;
      r_wq2 <= '0;
    end else begin
      r_wq1 <= wptr_gray;
      r_wq2 <= r_wq1;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_rbin  <= '0;
      r_rgray <= '0;
    end else begin
      r_rbin  <= w_rbin_next;
      r_rgray <= w_rgray_next;
    end
  end

  // Flags look at the post-read pointer so the last read empties at once.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_uflow  <= 1'b0;
    end else begin
      r_empty  <= (w_rgray_next == r_wq2);
      r_aempty <= (w_occ <= PW'(AEMPTY_THRESH));
      r_uflow  <= rden & r_empty;
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_odata <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_odata <= rdata_mem;
      end
    end
  end

  assign raddr           = r_rbin[ADDRSIZE-1:0];
  assign rptr_gray       = r_rgray;
  assign odata           = r_odata;
  assign rd_valid        = r_valid;
  assign rd_empty        = r_empty;
  assign rd_almost_empty = r_aempty;
  assign rd_underflow    = r_uflow;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed scenarios plus random traffic
// checked against a count-based occupancy model.
module tb_fifo_rd_ctrl;

  logic       rclk = 1'b0;
  logic       rrst = 1'b0;
  logic       rden = 1'b0;
  logic [4:0] wptr_gray = '0;
  logic [7:0] rdata_mem;
  logic [3:0] raddr;
  logic [4:0] rptr_gray;
  logic [7:0] odata;
  logic       rd_valid;
  logic       rd_empty;
  logic       rd_almost_empty;
  logic       rd_underflow;

  logic [7:0] mem [16];
  int         wcnt = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  // Reference model: plain counts, two-cycle delayed view of writes.
  int         m_rcnt = 0;
  int         m_wq1 = 0;
  int         m_wq2 = 0;
  logic [7:0] m_odata = '0;
  logic       m_valid = 1'b0;
  logic       m_empty = 1'b1;
  logic       m_aempty = 1'b1;
  logic       m_uflow = 1'b0;

  fifo_rd_ctrl #(
    .DATASIZE(8),
    .ADDRSIZE(4),
    .AEMPTY_THRESH(2)
  ) dut (
    .rclk(rclk),
    .rrst(rrst),
    .rden(rden),
    .wptr_gray(wptr_gray),
    .rdata_mem(rdata_mem),
    .raddr(raddr),
    .rptr_gray(rptr_gray),
    .odata(odata),
    .rd_valid(rd_valid),
    .rd_empty(rd_empty),
    .rd_almost_empty(rd_almost_empty),
    .rd_underflow(rd_underflow)
  );

  assign rdata_mem = mem[raddr];

  always #5 rclk = ~rclk;

  function automatic logic [4:0] gray(input int b);
    return 5'(b ^ (b >> 1));
  endfunction

  always @(posedge rclk or posedge rrst) begin
    int acc;
    int occ;
    if (rrst) begin
      m_rcnt = 0;
      m_wq1 = 0;
      m_wq2 = 0;
      m_odata = '0;
      m_valid = 1'b0;
      m_empty = 1'b1;
      m_aempty = 1'b1;
      m_uflow = 1'b0;
    end else begin
      acc = (rden && !m_empty) ? 1 : 0;
      m_uflow = rden && m_empty;
      m_valid = (acc == 1);
      if (acc == 1) begin
        m_odata = mem[m_rcnt % 16];
        m_rcnt = (m_rcnt + 1) % 32;
      end
      occ = (m_wq2 - m_rcnt + 32) % 32;
      m_empty = (occ == 0);
      m_aempty = (occ <= 2);
      m_wq2 = m_wq1;
      m_wq1 = wcnt;
    end
  end

  task automatic tick();
    @(posedge rclk);
    @(negedge rclk);
  endtask

  task automatic write_word(input logic [7:0] d);
    mem[wcnt % 16] = d;
    wcnt = (wcnt + 1) % 32;
    wptr_gray = gray(wcnt);
  endtask

  task automatic test_reset();
    @(negedge rclk);
    rden = 1'b1;
    wptr_gray = 5'h03;
    #2 rrst = 1'b1;
    #1;
    n_tests++;
    if (rd_empty !== 1'b1 || rd_almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_flags: empty=%b aempty=%b want 1 1",
               rd_empty, rd_almost_empty);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (rd_underflow !== 1'b0 || rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_pulse: uflow=%b valid=%b want 0 0",
                 rd_underflow, rd_valid);
      end
    end
    n_tests++;
    if (raddr !== 4'd0 || rptr_gray !== 5'd0 || odata !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_ptrs: raddr=%h rgray=%h odata=%h want 0 0 0",
               raddr, rptr_gray, odata);
    end
    rden = 1'b0;
    wcnt = 0;
    wptr_gray = '0;
    rrst = 1'b0;
  endtask

  task automatic test_first_word();
    write_word(8'hA5);
    tick();
    tick();
    n_tests++;
    if (rd_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_early: empty=%b want 1", rd_empty);
    end
    tick();
    n_tests++;
    if (rd_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_third: empty=%b want 0", rd_empty);
    end
    rden = 1'b1;
    tick();
    rden = 1'b0;
    n_tests++;
    if (odata !== 8'hA5 || rd_valid !== 1'b1 ||
        rptr_gray !== 5'h01 || rd_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL first_read: odata=%h v=%b rg=%h e=%b want a5 1 01 1",
               odata, rd_valid, rptr_gray, rd_empty);
    end
  endtask

  task automatic test_underflow();
    logic [3:0] a0;
    logic [7:0] d0;
    a0 = raddr;
    d0 = odata;
    rden = 1'b1;
    tick();
    rden = 1'b0;
    n_tests++;
    if (rd_underflow !== 1'b1 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL uflow_pulse: uflow=%b valid=%b want 1 0",
               rd_underflow, rd_valid);
    end
    n_tests++;
    if (raddr !== a0 || odata !== d0) begin
      n_fail++;
      $display("FAIL uflow_hold: raddr=%h odata=%h want %h %h",
               raddr, odata, a0, d0);
    end
    tick();
    n_tests++;
    if (rd_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL uflow_len: uflow=%b want 0", rd_underflow);
    end
  endtask

  task automatic test_almost_empty();
    write_word(8'h11);
    write_word(8'h22);
    write_word(8'h33);
    tick();
    tick();
    tick();
    n_tests++;
    if (rd_almost_empty !== 1'b0 || rd_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL aempty_occ3: ae=%b e=%b want 0 0",
               rd_almost_empty, rd_empty);
    end
    rden = 1'b1;
    tick();
    rden = 1'b0;
    n_tests++;
    if (rd_almost_empty !== 1'b1 || odata !== 8'h11) begin
      n_fail++;
      $display("FAIL aempty_occ2: ae=%b odata=%h want 1 11",
               rd_almost_empty, odata);
    end
    rden = 1'b1;
    tick();
    tick();
    rden = 1'b0;
    n_tests++;
    if (rd_empty !== 1'b1 || odata !== 8'h33) begin
      n_fail++;
      $display("FAIL aempty_drain: e=%b odata=%h want 1 33",
               rd_empty, odata);
    end
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    int         wraps;
    wraps = 0;
    for (int i = 0; i < 32; i++) begin
      write_word(8'(i));
      tick();
      tick();
      tick();
      prev = rptr_gray;
      rden = 1'b1;
      tick();
      rden = 1'b0;
      n_tests++;
      if (odata !== 8'(i) || rd_underflow !== 1'b0 ||
          $countones(prev ^ rptr_gray) != 1 ||
          rptr_gray !== gray(m_rcnt)) begin
        n_fail++;
        $display("FAIL wrap_seq%0d: odata=%h uf=%b rg=%h->%h want %h",
                 i, odata, rd_underflow, prev, rptr_gray, 8'(i));
      end
      if (prev == 5'h10) begin
        wraps++;
        n_tests++;
        if (rptr_gray !== 5'h00) begin
          n_fail++;
          $display("FAIL wrap_edge: rg=%h want 00", rptr_gray);
        end
      end
    end
    n_tests++;
    if (wraps != 1) begin
      n_fail++;
      $display("FAIL wrap_seen: wraps=%0d want 1", wraps);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) write_word(8'($urandom));
    tick();
    tick();
    tick();
    rden = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rden = 1'b0;
    #3 rrst = 1'b1;
    #1;
    n_tests++;
    if (raddr !== 4'd0 || rptr_gray !== 5'd0 || odata !== 8'd0 ||
        rd_valid !== 1'b0 || rd_empty !== 1'b1 ||
        rd_almost_empty !== 1'b1 || rd_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: a=%h rg=%h d=%h v=%b e=%b ae=%b uf=%b",
               raddr, rptr_gray, odata, rd_valid, rd_empty,
               rd_almost_empty, rd_underflow);
    end
    wcnt = 0;
    wptr_gray = '0;
    @(negedge rclk);
    rrst = 1'b0;
    write_word(8'h77);
    tick();
    tick();
    tick();
    n_tests++;
    if (raddr !== 4'd0 || rd_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_addr: raddr=%h e=%b want 0 0",
               raddr, rd_empty);
    end
    rden = 1'b1;
    tick();
    rden = 1'b0;
    n_tests++;
    if (odata !== 8'h77 || raddr !== 4'd1) begin
      n_fail++;
      $display("FAIL resume_data: odata=%h raddr=%h want 77 1",
               odata, raddr);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rden = ($urandom_range(0, 1) == 1);
      if ((wcnt - m_rcnt + 32) % 32 < 16 && $urandom_range(0, 1) == 1) begin
        write_word(8'($urandom));
      end
      tick();
      n_tests++;
      if (odata !== m_odata || rd_valid !== m_valid ||
          rd_empty !== m_empty || rd_almost_empty !== m_aempty ||
          rd_underflow !== m_uflow ||
          raddr !== 4'(m_rcnt % 16) || rptr_gray !== gray(m_rcnt)) begin
        n_fail++;
        $display("FAIL random_c%0d: d=%h v=%b e=%b ae=%b uf=%b a=%h rg=%h",
                 c, odata, rd_valid, rd_empty, rd_almost_empty,
                 rd_underflow, raddr, rptr_gray);
        $display("  want d=%h v=%b e=%b ae=%b uf=%b a=%h rg=%h",
                 m_odata, m_valid, m_empty, m_aempty, m_uflow,
                 4'(m_rcnt % 16), gray(m_rcnt));
      end
    end
    rden = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_first_word();
    test_underflow();
    test_almost_empty();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
